// File: rtl/sigmoid_pipe_if.sv
// Valid/ready bundle for sigmoid_pipe: upstream sample channel plus downstream result channel.
interface sigmoid_pipe_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_mode;
  logic        [TAG_W-1:0]  in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic        [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/sigmoid_pipe.sv
// Three-stage shift-add piecewise-linear sigmoid/tanh on signed fixed-point samples.
// All stages advance together when the output register is empty or being drained.
module sigmoid_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 11,
  parameter int TAG_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sigmoid_pipe_if.slave bus,
  output logic          busy
);
  localparam int IW = DATA_W + 2;
  localparam logic signed [DATA_W-1:0] MAXP_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MINN_D = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [IW-1:0] MAXP    = IW'(MAXP_D);
  localparam logic signed [IW-1:0] MINN    = IW'(MINN_D);
  localparam logic signed [IW-1:0] ONE     = IW'(1) <<< FRAC_W;
  localparam logic signed [IW-1:0] HALF    = ONE >>> 1;
  localparam logic signed [IW-1:0] SEG_HI  = ONE + (ONE <<< 2);
  localparam logic signed [IW-1:0] SEG_MID = IW'(19) <<< (FRAC_W - 3);
  localparam logic signed [IW-1:0] OFS_MID = IW'(27) <<< (FRAC_W - 5);
  localparam logic signed [IW-1:0] OFS_LO  = IW'(5) <<< (FRAC_W - 3);

  function automatic logic signed [DATA_W-1:0] sat_dw(input logic signed [IW-1:0] v);
    if (v > MAXP)      return MAXP_D;
    else if (v < MINN) return MINN_D;
    else               return v[DATA_W-1:0];
  endfunction

  function automatic logic signed [IW-1:0] abs_sat(input logic signed [IW-1:0] v);
    if (v == MINN)     return MAXP;
    else if (v[IW-1])  return -v;
    else               return v;
  endfunction

  function automatic logic signed [IW-1:0] prescale(input logic signed [DATA_W-1:0] x,
                                                    input logic mode);
    logic signed [IW-1:0] xe;
    logic signed [IW-1:0] t;
    xe = IW'(x);
    t  = mode ? (xe <<< 1) : xe;
    return abs_sat(IW'(sat_dw(t)));
  endfunction

  function automatic logic signed [IW-1:0] seg_eval(input logic signed [IW-1:0] a);
    if (a >= SEG_HI)       return ONE;
    else if (a >= SEG_MID) return (a >>> 5) + OFS_MID;
    else if (a >= ONE)     return (a >>> 3) + OFS_LO;
    else                   return (a >>> 2) + HALF;
  endfunction

  // Result already lies in [-ONE, ONE]; the clamp only narrows the width.
  function automatic logic signed [DATA_W-1:0] fold_post(input logic signed [IW-1:0] p,
                                                         input logic neg, input logic mode);
    logic signed [IW-1:0] s;
    logic signed [IW-1:0] o;
    s = neg ? ONE - p : p;
    o = mode ? (s <<< 1) - ONE : s;
    return sat_dw(o);
  endfunction

  logic                     adv;
  logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, out_valid_q, out_valid_d;
  logic                     neg_p1_q, neg_p1_d, neg_p2_q, neg_p2_d;
  logic                     mode_p1_q, mode_p1_d, mode_p2_q, mode_p2_d;
  logic        [TAG_W-1:0]  tag_p1_q, tag_p1_d, tag_p2_q, tag_p2_d, out_tag_q, out_tag_d;
  logic signed [IW-1:0]     a_p1_q, a_p1_d, p_p2_q, p_p2_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;

  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = vld_p1_q | vld_p2_q | out_valid_q;

  always_comb begin
    vld_p1_d    = vld_p1_q;
    neg_p1_d    = neg_p1_q;
    mode_p1_d   = mode_p1_q;
    tag_p1_d    = tag_p1_q;
    a_p1_d      = a_p1_q;
    vld_p2_d    = vld_p2_q;
    neg_p2_d    = neg_p2_q;
    mode_p2_d   = mode_p2_q;
    tag_p2_d    = tag_p2_q;
    p_p2_d      = p_p2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (adv) begin
      // stage 1: sign, optional doubling for tanh, magnitude
      vld_p1_d = bus.in_valid;
      if (bus.in_valid) begin
        neg_p1_d  = bus.in_data[DATA_W-1];
        mode_p1_d = bus.in_mode;
        tag_p1_d  = bus.in_tag;
        a_p1_d    = prescale(bus.in_data, bus.in_mode);
      end
      // stage 2: segment select and shift-add
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        neg_p2_d  = neg_p1_q;
        mode_p2_d = mode_p1_q;
        tag_p2_d  = tag_p1_q;
        p_p2_d    = seg_eval(a_p1_q);
      end
      // stage 3: fold negative half, tanh post-map, output register
      out_valid_d = vld_p2_q;
      if (vld_p2_q) begin
        out_data_d = fold_post(p_p2_q, neg_p2_q, mode_p2_q);
        out_tag_d  = tag_p2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    neg_p1_q  <= neg_p1_d;
    mode_p1_q <= mode_p1_d;
    tag_p1_q  <= tag_p1_d;
    a_p1_q    <= a_p1_d;
    neg_p2_q  <= neg_p2_d;
    mode_p2_q <= mode_p2_d;
    tag_p2_q  <= tag_p2_d;
    p_p2_q    <= p_p2_d;
  end
endmodule

// File: tb/tb_sigmoid_pipe.sv
// Directed and randomised bench for sigmoid_pipe at the default Q5.11 format.
module tb_sigmoid_pipe;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 11;
  localparam int TAG_W  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] vx[8];
  logic [15:0] ve[8];
  logic        vm[8];

  sigmoid_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  sigmoid_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Integer reference of the piecewise-linear curve, Q5.11.
  function automatic logic [15:0] ref_model(input logic [15:0] xin, input logic m);
    int x, t, a, p, s, o;
    x = int'($signed(xin));
    t = m ? 2 * x : x;
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    a = (t < 0) ? -t : t;
    if (a > 32767) a = 32767;
    if (a >= 10240)     p = 2048;
    else if (a >= 4864) p = a / 32 + 1728;
    else if (a >= 2048) p = a / 8 + 1280;
    else                p = a / 4 + 1024;
    s = (x < 0) ? 2048 - p : p;
    o = m ? 2 * s - 2048 : s;
    return o[15:0];
  endfunction

  task automatic set_vec(input int i, input logic [15:0] x, input logic m, input logic [15:0] e);
    vx[i] = x;
    vm[i] = m;
    ve[i] = e;
  endtask

  // Back-to-back stream with out_ready high; result j is due 3 edges after its input.
  task automatic run_stream(input string nm, input int n);
    for (int j = 0; j < n + 3; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        check_val({nm, "_vld"}, 16'(bus.out_valid), 16'd1);
        check_val(nm, bus.out_data, ve[j-3]);
        check_val({nm, "_tag"}, 16'(bus.out_tag), 16'(j - 3));
      end else if (j >= 1) begin
        check_val({nm, "_lat"}, 16'(bus.out_valid), 16'd0);
      end
      if (j < n) begin
        bus.in_valid = 1'b1;
        bus.in_data  = vx[j];
        bus.in_mode  = vm[j];
        bus.in_tag   = TAG_W'(j);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  // Handshaked flow with a scoreboard; rnd selects random traffic, else a fixed 5-cycle stall.
  task automatic run_flow(input string nm, input int n, input bit rnd, input int budget);
    logic [15:0]      exp_q[$];
    logic [TAG_W-1:0] tag_q[$];
    logic [15:0]      prev_d;
    logic [TAG_W-1:0] prev_t;
    logic [15:0]      x;
    logic             m;
    bit               prev_stall;
    bit               pend;
    int               sent, rcv, cyc;
    prev_stall = 0; pend = 0; sent = 0; rcv = 0; cyc = 0;
    prev_d = '0; prev_t = '0; x = '0; m = 1'b0;
    while (rcv < n && cyc < budget) begin
      @(negedge clk);
      bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc < 9);
      if (!pend && sent < n && (!rnd || $urandom_range(0, 2) != 0)) begin
        x = rnd ? 16'($urandom()) : vx[sent];
        m = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in_data  = x;
        bus.in_mode  = m;
        bus.in_tag   = TAG_W'(sent);
        bus.in_valid = 1'b1;
        pend = 1;
      end else if (!pend) begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        check_val({nm, "_inrdy"}, 16'(bus.in_ready), 16'd0);
        if (prev_stall) begin
          check_val({nm, "_hold_data"}, bus.out_data, prev_d);
          check_val({nm, "_hold_tag"}, 16'(bus.out_tag), 16'(prev_t));
        end
        prev_stall = 1;
        prev_d = bus.out_data;
        prev_t = bus.out_tag;
      end else begin
        prev_stall = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val({nm, "_extra"}, 16'(exp_q.size()), 16'd1);
        end else begin
          check_val({nm, "_data"}, bus.out_data, exp_q.pop_front());
          check_val({nm, "_tag"}, 16'(bus.out_tag), 16'(tag_q.pop_front()));
        end
        rcv++;
      end
      if (pend && bus.in_ready) begin
        exp_q.push_back(rnd ? ref_model(x, m) : ve[sent]);
        tag_q.push_back(TAG_W'(sent));
        sent++;
        pend = 0;
      end
      cyc++;
    end
    check_val({nm, "_count"}, 16'(rcv), 16'(n));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_val({nm, "_drain_busy"}, 16'(busy), 16'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check_val("rst_busy", 16'(busy), 16'd0);
    check_val("rst_out_data", bus.out_data, 16'h0000);
    check_val("rst_out_tag", 16'(bus.out_tag), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_in_ready", 16'(bus.in_ready), 16'd1);

    set_vec(0, 16'hE000, 1'b0, 16'h0040);
    set_vec(1, 16'hF800, 1'b0, 16'h0200);
    set_vec(2, 16'h0000, 1'b0, 16'h0400);
    set_vec(3, 16'h0400, 1'b0, 16'h0500);
    set_vec(4, 16'h0800, 1'b0, 16'h0600);
    set_vec(5, 16'h2000, 1'b0, 16'h07C0);
    set_vec(6, 16'h2800, 1'b0, 16'h0800);
    run_stream("sig", 7);

    set_vec(0, 16'h0400, 1'b1, 16'h0400);
    set_vec(1, 16'hF800, 1'b1, 16'hFA00);
    set_vec(2, 16'h0000, 1'b1, 16'h0000);
    set_vec(3, 16'h7FFF, 1'b1, 16'h0800);
    set_vec(4, 16'h8000, 1'b1, 16'hF800);
    run_stream("tanh", 5);

    set_vec(0, 16'h0400, 1'b0, 16'h0500);
    set_vec(1, 16'h0400, 1'b1, 16'h0400);
    set_vec(2, 16'hF800, 1'b0, 16'h0200);
    set_vec(3, 16'hF800, 1'b1, 16'hFA00);
    run_stream("mixed", 4);

    set_vec(0, 16'h07FF, 1'b0, 16'h05FF);
    set_vec(1, 16'h0800, 1'b0, 16'h0600);
    set_vec(2, 16'h12FF, 1'b0, 16'h075F);
    set_vec(3, 16'h1300, 1'b0, 16'h0758);
    set_vec(4, 16'h27FF, 1'b0, 16'h07FF);
    set_vec(5, 16'h2800, 1'b0, 16'h0800);
    run_stream("seg", 6);

    set_vec(0, 16'hE000, 1'b0, 16'h0040);
    set_vec(1, 16'hF800, 1'b0, 16'h0200);
    set_vec(2, 16'h0000, 1'b0, 16'h0400);
    set_vec(3, 16'h0400, 1'b0, 16'h0500);
    set_vec(4, 16'h0800, 1'b0, 16'h0600);
    set_vec(5, 16'h2000, 1'b0, 16'h07C0);
    set_vec(6, 16'h2800, 1'b0, 16'h0800);
    set_vec(7, 16'h1300, 1'b0, 16'h0758);
    run_flow("bp", 8, 1'b0, 60);

    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0400;
      bus.in_mode  = 1'b0;
      bus.in_tag   = TAG_W'(9 + j);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("inflight_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    check_val("midrst_busy", 16'(busy), 16'd0);
    check_val("midrst_out_data", bus.out_data, 16'h0000);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hF800;
    bus.in_mode  = 1'b1;
    bus.in_tag   = TAG_W'(5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("postrst_lat1", 16'(bus.out_valid), 16'd0);
    @(negedge clk);
    check_val("postrst_lat2", 16'(bus.out_valid), 16'd0);
    @(negedge clk);
    check_val("postrst_vld", 16'(bus.out_valid), 16'd1);
    check_val("postrst_data", bus.out_data, 16'hFA00);
    check_val("postrst_tag", 16'(bus.out_tag), 16'd5);

    run_flow("rnd", 10000, 1'b1, 60000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
